adc_frame_align: RTL and testbench

//   Word-framing stage between the per-channel ADC deserializer and the pattern

---
 rtl/adc_frame_align.sv | 138 +++++++++++++
 tb/tb_adc_frame_align.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_align.sv
// Word-framing stage for one ADC channel: rotates the raw 12-bit stream by 0..11 bits,
// hunts for the 1x-sync training word and freezes the offset once it has been seen.
module adc_frame_align #(
    parameter logic [11:0] SYNC       = 12'h07F,
    parameter int          SETTLE_CYC = 4,
    parameter int          MATCH_LEN  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] raw,
    input  logic        start,
    output logic [11:0] data,
    output logic [3:0]  offset,
    output logic        busy,
    output logic        locked,
    output logic        fail
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    localparam int              SCNT_W      = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_CYC - 1);
    localparam logic [7:0]      MCNT_LAST   = 8'(MATCH_LEN - 1);
    localparam logic [3:0]      LAST_OFFSET = 4'd11;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_offset;
    logic [3:0]        w_offset_nxt;
    logic [SCNT_W-1:0] r_scnt;
    logic [SCNT_W-1:0] w_scnt_nxt;
    logic [7:0]        r_mcnt;
    logic [7:0]        w_mcnt_nxt;
    logic [11:0]       r_raw_d;
    logic [11:0]       r_data;
    logic [23:0]       w_cat;
    logic [11:0]       w_win;
    logic              w_match;

    // Window k starts k bits later in the serial stream; offsets 12..15 fall back to window 0.
    always_comb begin
        w_cat = {r_raw_d, raw};
        w_win = w_cat[23:12];
        if (r_offset <= LAST_OFFSET) begin
            w_win = w_cat[5'd23 - {1'b0, r_offset} -: 12];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_raw_d <= '0;
            r_data  <= '0;
        end else begin
            r_raw_d <= raw;
            r_data  <= w_win;
        end
    end

    assign w_match = (r_data == SYNC);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_offset <= '0;
            r_scnt   <= '0;
            r_mcnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_offset <= w_offset_nxt;
            r_scnt   <= w_scnt_nxt;
            r_mcnt   <= w_mcnt_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_offset_nxt = r_offset;
        w_scnt_nxt   = r_scnt;
        w_mcnt_nxt   = r_mcnt;
        if (start) begin
            w_state_nxt  = ST_SETTLE;
            w_offset_nxt = '0;
            w_scnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (r_scnt == SCNT_LAST) begin
                        w_state_nxt = ST_CHECK;
                        w_mcnt_nxt  = '0;
                    end else begin
                        w_scnt_nxt = r_scnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_match) begin
                        if (r_mcnt == MCNT_LAST) begin
                            w_state_nxt = ST_LOCKED;
                        end else begin
                            w_mcnt_nxt = r_mcnt + 8'd1;
                        end
                    end else if (r_offset == LAST_OFFSET) begin
                        w_state_nxt = ST_FAIL;
                    end else begin
                        w_offset_nxt = r_offset + 4'd1;
                        w_scnt_nxt   = '0;
                        w_state_nxt  = ST_SETTLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Flags decode the state register, so they move one clock after the deciding compare.
    always_comb begin
        busy   = 1'b0;
        locked = 1'b0;
        fail   = 1'b0;
        case (r_state)
            ST_SETTLE, ST_CHECK: busy   = 1'b1;
            ST_LOCKED:           locked = 1'b1;
            ST_FAIL:             fail   = 1'b1;
            default: ;
        endcase
    end

    assign data   = r_data;
    assign offset = r_offset;

endmodule

// File: tb/tb_adc_frame_align.sv
// Bench for adc_frame_align: a stream-level reference model feeds a scoreboard queue checked
// every cycle, plus lock-time / outcome checks derived from the training timing rules.
module tb_adc_frame_align;

    localparam logic [11:0] SYNC       = 12'h07F;
    localparam int          SETTLE_CYC = 4;
    localparam int          MATCH_LEN  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] raw;
    logic [11:0] data;
    logic [3:0]  offset;
    logic        busy;
    logic        locked;
    logic        fail;

    always #5 clk = ~clk;

    adc_frame_align #(
        .SYNC      (SYNC),
        .SETTLE_CYC(SETTLE_CYC),
        .MATCH_LEN (MATCH_LEN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .raw   (raw),
        .start (start),
        .data  (data),
        .offset(offset),
        .busy  (busy),
        .locked(locked),
        .fail  (fail)
    );

    typedef struct {
        logic [11:0] data;
        logic [3:0]  offset;
        logic        busy;
        logic        locked;
        logic        fail;
    } exp_t;

    typedef enum {M_IDLE, M_HUNT, M_LOCK, M_FAIL} mmode_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: mode, current offset, clocks spent at that offset, run of good words.
    mmode_t      m_mode;
    int          m_off;
    int          m_age;
    int          m_run;
    logic [11:0] m_raw_d;
    logic [11:0] m_data;

    function automatic logic [11:0] window(input logic [11:0] prev, input logic [11:0] cur, input int off);
        logic [23:0] c;
        int          o;
        o = (off > 11) ? 0 : off;
        c = {prev, cur};
        c = c >> (12 - o);
        return c[11:0];
    endfunction

    function automatic logic [11:0] rotr(input logic [11:0] x, input int k);
        logic [23:0] t;
        t = {x, x};
        t = t >> k;
        return t[11:0];
    endfunction

    task automatic model_step(input logic rs, input logic st, input logic [11:0] rw);
        exp_t        e;
        logic [11:0] seen;
        logic [11:0] nd;
        if (rs) begin
            m_mode  = M_IDLE;
            m_off   = 0;
            m_age   = 0;
            m_run   = 0;
            m_raw_d = '0;
            m_data  = '0;
        end else begin
            seen = m_data;
            nd   = window(m_raw_d, rw, m_off);
            if (st) begin
                m_mode = M_HUNT;
                m_off  = 0;
                m_age  = 0;
                m_run  = 0;
            end else if (m_mode == M_HUNT) begin
                if (m_age < SETTLE_CYC) begin
                    m_age++;
                end else if (seen == SYNC) begin
                    m_run++;
                    if (m_run == MATCH_LEN) m_mode = M_LOCK;
                end else if (m_off == 11) begin
                    m_mode = M_FAIL;
                end else begin
                    m_off++;
                    m_age = 0;
                    m_run = 0;
                end
            end
            m_raw_d = rw;
            m_data  = nd;
        end
        e.data   = m_data;
        e.offset = 4'(m_off);
        e.busy   = (m_mode == M_HUNT);
        e.locked = (m_mode == M_LOCK);
        e.fail   = (m_mode == M_FAIL);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic rs, input logic st, input logic [11:0] rw);
        @(negedge clk);
        reset = rs;
        start = st;
        raw   = rw;
        model_step(rs, st, rw);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Scoreboard monitor: one expected record per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({data, offset, busy, locked, fail} !== {e.data, e.offset, e.busy, e.locked, e.fail}) begin
                    n_bad++;
                    $display("FAIL cycle_out @%0t: data=%h off=%0d busy=%b locked=%b fail=%b, expected data=%h off=%0d busy=%b locked=%b fail=%b",
                             $time, data, offset, busy, locked, fail,
                             e.data, e.offset, e.busy, e.locked, e.fail);
                end
            end
        end
    end

    // One training run started at step 0. Step i's drive is sampled by edge s+i; outputs read
    // during step i show the state after edge s+i-1. len is the edge count from start to flag.
    task automatic run_search(input string name, input logic [11:0] word, input int corrupt_at,
                              input int restart_at, input int probe_at, input int probe_off,
                              input int exp_len, input logic exp_lock, input int exp_off,
                              input int tail, input logic rand_tail);
        int          t0;
        int          len;
        int          after;
        logic        st;
        logic [11:0] rw;
        t0    = 0;
        len   = -1;
        after = 0;
        for (int i = 0; i < 600; i++) begin
            if (i == restart_at) t0 = i;
            st = (i == 0) || (i == restart_at);
            rw = (i == corrupt_at) ? ~word : word;
            if (len >= 0 && rand_tail) rw = 12'($urandom);
            drive(1'b0, st, rw);
            if (i == t0 + 1) begin
                check({name, " start_offset"}, 32'(offset), 32'd0);
                check({name, " start_busy"}, 32'(busy), 32'd1);
                check({name, " start_flags"}, 32'({locked, fail}), 32'd0);
            end
            if (i == probe_at) check({name, " probe_offset"}, 32'(offset), 32'(probe_off));
            if (len < 0 && i > t0 && (locked || fail)) len = i - 1 - t0;
            if (len >= 0) after++;
            if (after > tail) break;
        end
        check({name, " decide_time"}, 32'(len), 32'(exp_len));
        check({name, " locked"}, 32'(locked), 32'(exp_lock));
        check({name, " fail"}, 32'(fail), 32'(!exp_lock));
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " offset"}, 32'(offset), 32'(exp_off));
    endtask

    function automatic int lock_time(input int k);
        return (k + 1) * SETTLE_CYC + k + MATCH_LEN;
    endfunction

    initial begin
        int k;
        reset = 1'b1;
        start = 1'b0;
        raw   = '0;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 12'h000);
        drive(1'b0, 1'b0, 12'h123);
        check("reset_state", 32'({data, offset, busy, locked, fail}), 32'd0);

        run_search("aligned", SYNC, -1, -1, -1, 0, lock_time(0), 1'b1, 0, 8, 1'b0);
        run_search("shift5", rotr(SYNC, 5), -1, -1, -1, 0, lock_time(5), 1'b1, 5, 20, 1'b0);
        run_search("const_aaa", 12'hAAA, -1, -1, -1, 0, 12 * (SETTLE_CYC + 1), 1'b0, 11, 6, 1'b0);
        // Corrupted word compared when 10 matches are counted at offset 3, then offsets 4..11 fail.
        run_search("glitch_m10", rotr(SYNC, 3), 29, -1, 31, 4, 70, 1'b0, 11, 4, 1'b0);
        // Fifteen matches then a mismatch must not lock.
        run_search("glitch_m15", rotr(SYNC, 3), 34, -1, 36, 4, 75, 1'b0, 11, 4, 1'b0);
        // Restart in the middle of the match run at offset 7, then again while locked.
        run_search("restart_mid", rotr(SYNC, 7), -1, 47, -1, 0, lock_time(7), 1'b1, 7, 6, 1'b0);
        run_search("restart_lock", rotr(SYNC, 7), -1, -1, -1, 0, lock_time(7), 1'b1, 7, 12, 1'b1);

        for (int r = 0; r < 5; r++) begin
            k = $urandom_range(0, 11);
            run_search($sformatf("rand_k%0d", k), rotr(SYNC, k), -1, -1, -1, 0,
                       lock_time(k), 1'b1, k, 10, 1'b1);
        end

        // Reset together with start during SETTLE: reset wins and the block returns to idle.
        drive(1'b0, 1'b1, SYNC);
        drive(1'b0, 1'b0, SYNC);
        drive(1'b1, 1'b1, SYNC);
        drive(1'b0, 1'b0, SYNC);
        check("reset_vs_start_outputs", 32'({data, offset, busy, locked, fail}), 32'd0);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 12'($urandom));
        check("reset_vs_start_idle", 32'({offset, busy, locked, fail}), 32'd0);

        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
